nios_mem_arbiter: RTL and testbench
===================================

Name: nios_mem_arbiter

Overview:
- Shares one single-port synchronous memory between the NIOS_II instruction-fetch path (I port) and the load/store path (D port).
- Arbitrates between the two, sequences each access through issue, wait and response states, and returns read data with a one-cycle valid pulse.
- Data has priority, with a starvation guard so fetch always makes progress.
- Sits between the core's pc/inst_out and mem_read/mem_write logic and the memory macro.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; must be >= 1
- STARVE_LIMIT, 3, max consecutive D grants while i_req is pending; must be >= 1

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch grant pulse
- i_rvalid  out  1  fetch data valid pulse
- i_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data grant pulse
- d_rvalid  out  1  load-data or store-ack pulse
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  arbiter not in IDLE

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, starvation counter 0, owner = none.
- States:
  - IDLE: arbitration cycle.
  - ISSUE: exactly 1 cycle.
  - WAIT: MEM_LATENCY cycles.
  - RESP: 1 cycle, and also an arbitration cycle.
- Arbitration (evaluated in IDLE and RESP): a req high in an arbitration cycle is a new request.
  - If neither req is high: go to IDLE.
  - If only one req is high: that port wins.
  - If both are high: D wins, unless starve_cnt == STARVE_LIMIT, in which case I wins.
  - The winner's address, we and wdata are latched at the edge and the state goes to ISSUE.
- ISSUE:
  - x_gnt = 1 for the winner.
  - mem_en = 1, mem_addr/mem_we/mem_wdata = latched values; I accesses always have mem_we = 0.
  - Next state: WAIT.
- WAIT:
  - mem_en = 0 and memory outputs hold.
  - A counter runs MEM_LATENCY cycles. At the edge ending the last WAIT cycle, mem_rdata is captured into the winner's rdata, except for D stores, which leave d_rdata unchanged.
  - Next state: RESP.
- RESP:
  - The winner's x_rvalid = 1 for exactly one cycle; stores are acked via d_rvalid as well.
  - Arbitration runs in the same cycle: if a req is high, go to ISSUE, otherwise IDLE.
- Latency: req sampled at the end of cycle 0 -> gnt/mem_en in cycle 1 -> rvalid in cycle 2+MEM_LATENCY. Back-to-back accesses occupy MEM_LATENCY+2 cycles each.
- Requester rules:
  - Hold req, addr, we and wdata stable until gnt.
  - Drop req after gnt unless a further access is wanted; req is ignored in ISSUE and WAIT.
  - Requesters whose req is still high in RESP get a new access.
- Starvation counter (width $clog2(STARVE_LIMIT+1)):
  - +1 on each D grant made while i_req is high, saturating.
  - Cleared on any I grant, and on any arbitration cycle in which i_req is low.
- i_rdata/d_rdata hold their last captured value between accesses.
- busy = 1 in ISSUE, WAIT and RESP.
- Reset asserted mid-operation: immediately returns to IDLE with all outputs cleared. The in-flight access is dropped with no rvalid; the memory may have performed a write.
- No X propagation: the unused port's gnt and rvalid remain 0.

Test Plan:
- Reset:
  - Stimulus: hold reset = 1 from time 0 with clock toggling, then release at 10 ns.
  - Required: all outputs 0 and busy = 0 while reset is high; nothing asserts until a req is seen.
- Single fetch (MEM_LATENCY = 1):
  - Stimulus: i_req = 1, i_addr = 0x10 in cycle 0; memory supplies 0xDEADBEEF in cycle 2.
  - Required: i_gnt = mem_en = 1, mem_addr = 0x10, mem_we = 0 in cycle 1; i_rvalid = 1 with i_rdata = 0xDEADBEEF in cycle 3; busy cycles 1-3, then 0.
- Simultaneous requests:
  - Stimulus: i_req and d_req both high in cycle 0 (d_addr = 0x40, i_addr = 0x00); I held high.
  - Required: d_gnt in cycle 1 and d_rvalid in cycle 3; i_gnt in cycle 4 and i_rvalid in cycle 6.
- Starvation guard (STARVE_LIMIT = 3):
  - Stimulus: d_req and i_req both held high continuously.
  - Required: grant sequence D, D, D, I, D, D, D, I, ...; the counter clears after each I grant.
- Store:
  - Stimulus: d_req = 1, d_we = 1, d_addr = 0x20, d_wdata = 0x1234 in cycle 0, with d_rdata previously 0xAAAA.
  - Required: mem_en = mem_we = 1, mem_addr = 0x20, mem_wdata = 0x1234 in cycle 1; d_rvalid in cycle 3 with d_rdata still 0xAAAA.
- Reset mid-access:
  - Stimulus: start a fetch, then assert reset during the WAIT cycle (cycle 2) for 1 cycle.
  - Required: busy and all outputs drop to 0 asynchronously; no i_rvalid. A new fetch after release completes normally with gnt 1 cycle and rvalid MEM_LATENCY+2 cycles after req.

Source files
------------

// File: rtl/nios_mem_arbiter.sv
// nios_mem_arbiter: shares one single-port synchronous memory between the
// NIOS_II instruction-fetch port (I) and the load/store port (D).
// Latency: req seen in cycle 0 -> gnt/mem_en in cycle 1 -> rvalid in cycle
//          2+MEM_LATENCY; back-to-back accesses take MEM_LATENCY+2 cycles each.
// Backpressure: a requester holds req/addr/we/wdata until its gnt pulse; req is
//          only sampled in IDLE and RESP, so it is ignored while an access is
//          in flight. D has priority; after STARVE_LIMIT consecutive D grants
//          with I waiting, I is granted next.
//
// Ports:
//   clock, reset               rising-edge clock, async active-high reset
//   i_req/i_addr               fetch request and address
//   i_gnt/i_rvalid/i_rdata     fetch grant pulse, data-valid pulse, instruction
//   d_req/d_we/d_addr/d_wdata  load/store request (d_we=1 store)
//   d_gnt/d_rvalid/d_rdata     data grant pulse, load-data/store-ack pulse, data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory macro interface
//   busy                       high whenever the arbiter is not in IDLE
//
// Parameter constraints: MEM_LATENCY >= 1, STARVE_LIMIT >= 1.

module nios_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  // Access sequencer states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Which port owns the access currently in flight
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam int WCW = $clog2(MEM_LATENCY + 1);

  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(MEM_LATENCY - 1);

  // Control state
  logic [1:0]        state_q,      state_d;
  logic [WCW-1:0]    wait_cnt_q,   wait_cnt_d;
  logic [SCW-1:0]    starve_cnt_q, starve_cnt_d;
  logic [1:0]        owner_q,      owner_d;

  // Registered outputs
  logic              i_gnt_q,     i_gnt_d;
  logic              i_rvalid_q,  i_rvalid_d;
  logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
  logic              d_gnt_q,     d_gnt_d;
  logic              d_rvalid_q,  d_rvalid_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q,      busy_d;

  // Arbitration happens in IDLE and in RESP, so a requester that keeps its
  // req high through RESP is served with no idle bubble.
  logic arb_cycle;
  logic win_i;
  logic win_d;
  logic wait_done;

  assign arb_cycle = (state_q == S_IDLE) || (state_q == S_RESP);

  // D normally wins a tie; once D has been granted STARVE_LIMIT times in a row
  // while I was waiting, the tie goes to I.
  assign win_i = arb_cycle && i_req && (!d_req || (starve_cnt_q == STARVE_MAX));
  assign win_d = arb_cycle && d_req && !win_i;

  assign wait_done = (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;

    // Pulses default low; memory-side fields and read data hold their value.
    i_gnt_d      = 1'b0;
    d_gnt_d      = 1'b0;
    i_rvalid_d   = 1'b0;
    d_rvalid_d   = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      S_IDLE, S_RESP: begin
        // Starvation count only tracks D wins that actually made I wait.
        if (win_i || !i_req) begin
          starve_cnt_d = '0;
        end else if (win_d && (starve_cnt_q != STARVE_MAX)) begin
          starve_cnt_d = starve_cnt_q + SCW'(1);
        end

        if (win_i) begin
          state_d    = S_ISSUE;
          owner_d    = OWN_I;
          i_gnt_d    = 1'b1;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_addr;
        end else if (win_d) begin
          state_d     = S_ISSUE;
          owner_d     = OWN_D;
          d_gnt_d     = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end
      end

      S_ISSUE: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end

      S_WAIT: begin
        if (wait_done) begin
          // mem_rdata is valid now; capture it and raise rvalid for RESP.
          // mem_we_q still reflects the in-flight access, so it tells a
          // store (no capture) from a load.
          state_d = S_RESP;
          if (owner_q == OWN_I) begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = mem_rdata;
          end else if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      owner_q      <= OWN_NONE;
      i_gnt_q      <= 1'b0;
      i_rvalid_q   <= 1'b0;
      i_rdata_q    <= '0;
      d_gnt_q      <= 1'b0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      i_gnt_q      <= i_gnt_d;
      i_rvalid_q   <= i_rvalid_d;
      i_rdata_q    <= i_rdata_d;
      d_gnt_q      <= d_gnt_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign i_gnt     = i_gnt_q;
  assign i_rvalid  = i_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nios_mem_arbiter.sv
// tb_nios_mem_arbiter: directed scenarios plus a randomized run checked against
// a transaction-level model of the arbiter (grant order, timing, data).
// Latency/backpressure: not applicable (testbench).

module tb_nios_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 1;
  localparam int SL  = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  nios_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)
  ) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Synchronous memory macro: read data appears LAT cycles after mem_en.
  // A backdoor port lets the bench preload contents while the DUT is idle.
  logic [DW-1:0] mem     [0:255];
  logic [DW-1:0] rd_pipe [0:LAT-1];
  logic          bd_we   = 1'b0;
  logic [7:0]    bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  always @(posedge clock) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_en) rd_pipe[0] <= mem[mem_addr[7:0]];
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [134:0] all_outs();
    return {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
            mem_en, mem_we, mem_addr, mem_wdata, busy};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [DW-1:0] v);
    bd_we = 1'b1; bd_addr = a; bd_data = v;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #6;
    n_tests++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL reset_t6: outs=%h expected 0", all_outs());
    end
    #3;
    n_tests++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL reset_t9: outs=%h expected 0", all_outs());
    end
    #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (all_outs() !== '0) begin
        n_fail++; $display("FAIL reset_idle c%0d: outs=%h expected 0", c, all_outs());
      end
    end
  endtask

  task automatic test_single_fetch();
    bd_write(8'h10, 32'hDEADBEEF);
    i_req = 1'b1; i_addr = 32'h10;
    tick();  // cycle 1
    n_tests++;
    if ({i_gnt, d_gnt, mem_en, mem_we, busy} !== 5'b10101 || mem_addr !== 32'h10) begin
      n_fail++; $display("FAIL fetch_issue: gnt/dgnt/en/we/busy=%b addr=%h expected 10101 addr 10",
                         {i_gnt, d_gnt, mem_en, mem_we, busy}, mem_addr);
    end
    i_req = 1'b0;
    tick();  // cycle 2
    n_tests++;
    if ({i_gnt, i_rvalid, mem_en, busy} !== 4'b0001) begin
      n_fail++; $display("FAIL fetch_wait: gnt/rv/en/busy=%b expected 0001", {i_gnt, i_rvalid, mem_en, busy});
    end
    tick();  // cycle 3
    n_tests++;
    if ({i_rvalid, d_rvalid, busy} !== 3'b101 || i_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL fetch_resp: rv/drv/busy=%b rdata=%h expected 101 deadbeef",
                         {i_rvalid, d_rvalid, busy}, i_rdata);
    end
    tick();  // cycle 4
    n_tests++;
    if ({i_rvalid, busy} !== 2'b00 || i_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL fetch_after: rv/busy=%b rdata=%h expected 00 deadbeef", {i_rvalid, busy}, i_rdata);
    end
  endtask

  task automatic test_simultaneous();
    bd_write(8'h40, 32'hCAFE0040);
    bd_write(8'h00, 32'h0BADF00D);
    i_req = 1'b1; i_addr = 32'h00;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    tick();  // cycle 1
    n_tests++;
    if ({i_gnt, d_gnt} !== 2'b01 || mem_addr !== 32'h40) begin
      n_fail++; $display("FAIL simul_dgnt: igt/dgt=%b addr=%h expected 01 40", {i_gnt, d_gnt}, mem_addr);
    end
    d_req = 1'b0;
    tick(); tick();  // cycle 3
    n_tests++;
    if ({i_rvalid, d_rvalid} !== 2'b01 || d_rdata !== 32'hCAFE0040) begin
      n_fail++; $display("FAIL simul_drv: irv/drv=%b drdata=%h expected 01 cafe0040", {i_rvalid, d_rvalid}, d_rdata);
    end
    tick();  // cycle 4
    n_tests++;
    if ({i_gnt, d_gnt} !== 2'b10 || mem_addr !== 32'h00) begin
      n_fail++; $display("FAIL simul_igt: igt/dgt=%b addr=%h expected 10 0", {i_gnt, d_gnt}, mem_addr);
    end
    i_req = 1'b0;
    tick(); tick();  // cycle 6
    n_tests++;
    if ({i_rvalid, d_rvalid} !== 2'b10 || i_rdata !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL simul_irv: irv/drv=%b irdata=%h expected 10 0badf00d", {i_rvalid, d_rvalid}, i_rdata);
    end
    tick();  // cycle 7
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL simul_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_starvation();
    int cyc = 0;
    int last = 0;
    int waited;
    logic [1:0] exp;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    i_req = 1'b1; i_addr = 32'h00;
    for (int g = 0; g < 12; g++) begin
      waited = 0;
      do begin
        tick(); cyc++; waited++;
      end while (!(i_gnt || d_gnt) && waited < 10);
      exp = ((g % 4) == 3) ? 2'b10 : 2'b01;
      n_tests++;
      if (!(i_gnt || d_gnt)) begin
        n_fail++; $display("FAIL starve_timeout g%0d: no grant in 10 cycles", g);
      end else if ({i_gnt, d_gnt} !== exp) begin
        n_fail++; $display("FAIL starve_order g%0d: igt/dgt=%b expected %b", g, {i_gnt, d_gnt}, exp);
      end
      if (g > 0) begin
        n_tests++;
        if (cyc - last != LAT + 2) begin
          n_fail++; $display("FAIL starve_spacing g%0d: %0d cycles expected %0d", g, cyc - last, LAT + 2);
        end
      end
      last = cyc;
    end
    d_req = 1'b0; i_req = 1'b0;
    waited = 0;
    while (busy && waited < 10) begin
      tick(); waited++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL starve_drain: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_store();
    bd_write(8'h30, 32'h0000AAAA);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
    tick(); d_req = 1'b0;
    tick(); tick();
    n_tests++;
    if (d_rdata !== 32'h0000AAAA) begin
      n_fail++; $display("FAIL store_preload: drdata=%h expected 0000aaaa", d_rdata);
    end
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234;
    tick();  // cycle 1
    n_tests++;
    if ({d_gnt, i_gnt, mem_en, mem_we} !== 4'b1011 || mem_addr !== 32'h20 || mem_wdata !== 32'h1234) begin
      n_fail++; $display("FAIL store_issue: dgt/igt/en/we=%b addr=%h wdata=%h expected 1011 20 1234",
                         {d_gnt, i_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick(); tick();  // cycle 3
    n_tests++;
    if ({d_rvalid, i_rvalid} !== 2'b10 || d_rdata !== 32'h0000AAAA) begin
      n_fail++; $display("FAIL store_ack: drv/irv=%b drdata=%h expected 10 0000aaaa", {d_rvalid, i_rvalid}, d_rdata);
    end
    tick();
    d_req = 1'b1; d_addr = 32'h20;
    tick(); d_req = 1'b0;
    tick(); tick();
    n_tests++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h1234) begin
      n_fail++; $display("FAIL store_readback: drv=%b drdata=%h expected 1 1234", d_rvalid, d_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    i_req = 1'b1; i_addr = 32'h10;
    tick();  // cycle 1
    n_tests++;
    if (i_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_gnt: igt=%b expected 1", i_gnt);
    end
    i_req = 1'b0;
    tick();  // cycle 2 (WAIT)
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL rstmid_async: outs=%h expected 0", all_outs());
    end
    @(posedge clock);
    #1 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if (all_outs() !== '0) begin
        n_fail++; $display("FAIL rstmid_quiet c%0d: outs=%h expected 0", c, all_outs());
      end
    end
    bd_write(8'h44, 32'h44445555);
    i_req = 1'b1; i_addr = 32'h44;
    tick();  // cycle 1
    n_tests++;
    if ({i_gnt, mem_en} !== 2'b11 || mem_addr !== 32'h44) begin
      n_fail++; $display("FAIL rstmid_regnt: igt/en=%b addr=%h expected 11 44", {i_gnt, mem_en}, mem_addr);
    end
    i_req = 1'b0;
    tick();  // cycle 2
    n_tests++;
    if (i_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_early: irv=%b expected 0", i_rvalid);
    end
    tick();  // cycle 3
    n_tests++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'h44445555) begin
      n_fail++; $display("FAIL rstmid_resp: irv=%b irdata=%h expected 1 44445555", i_rvalid, i_rdata);
    end
    tick();
  endtask

  // Randomized traffic. The model treats the arbiter as a resource that is
  // free for a decision in any idle cycle and again in the response cycle of
  // each access; every grant reserves LAT+2 cycles and its data comes from a
  // shadow copy of memory updated in grant order.
  task automatic test_random();
    logic [DW-1:0] shadow [0:255];
    logic [5:0]    e_ctl  [0:31];   // {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, busy}
    logic [AW-1:0] e_addr [0:31];
    logic          e_we   [0:31];
    logic [DW-1:0] e_wd   [0:31];
    logic [DW-1:0] e_rd   [0:31];
    logic          e_ld   [0:31];
    logic [DW-1:0] cur_i, cur_d, v;
    int  next_arb, streak, slot, s1, sr;
    bit  i_pend, d_pend, win_i, win_d;

    reset = 1'b1;
    tick();
    reset = 1'b0;
    cur_i = '0; cur_d = '0;
    next_arb = 0; streak = 0; i_pend = 0; d_pend = 0;
    for (int a = 0; a < 256; a++) begin
      v = $urandom;
      shadow[a] = v;
      bd_write(8'(a), v);
    end
    for (int s = 0; s < 32; s++) begin
      e_ctl[s] = '0; e_addr[s] = '0; e_we[s] = 1'b0; e_wd[s] = '0; e_rd[s] = '0; e_ld[s] = 1'b0;
    end

    for (int c = 0; c < 500; c++) begin
      slot = c % 32;
      if (e_ctl[slot][3]) cur_i = e_rd[slot];
      if (e_ctl[slot][2] && e_ld[slot]) cur_d = e_rd[slot];
      n_tests++;
      if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, busy} !== e_ctl[slot]) begin
        n_fail++; $display("FAIL rand_ctl c%0d: igt/dgt/irv/drv/en/busy=%b expected %b", c,
                           {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, busy}, e_ctl[slot]);
      end
      n_tests++;
      if (i_rdata !== cur_i || d_rdata !== cur_d) begin
        n_fail++; $display("FAIL rand_data c%0d: irdata=%h drdata=%h expected %h %h", c, i_rdata, d_rdata, cur_i, cur_d);
      end
      if (e_ctl[slot][1]) begin
        n_tests++;
        if (mem_addr !== e_addr[slot] || mem_we !== e_we[slot] || (e_we[slot] && mem_wdata !== e_wd[slot])) begin
          n_fail++; $display("FAIL rand_mem c%0d: addr=%h we=%b wdata=%h expected %h %b %h", c,
                             mem_addr, mem_we, mem_wdata, e_addr[slot], e_we[slot], e_wd[slot]);
        end
      end
      if (e_ctl[slot][5]) i_pend = 0;
      if (e_ctl[slot][4]) d_pend = 0;
      e_ctl[slot] = '0; e_ld[slot] = 1'b0;

      if (c < 460) begin
        if (!i_pend && $urandom_range(0, 99) < 45) begin
          i_pend = 1; i_addr = $urandom;
        end
        if (!d_pend && $urandom_range(0, 99) < 55) begin
          d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
        end
      end
      i_req = i_pend; d_req = d_pend;

      if (c >= next_arb) begin
        win_i = i_req && (!d_req || streak == SL);
        win_d = d_req && !win_i;
        if (win_i || !i_req) streak = 0;
        else if (win_d && streak < SL) streak++;
        if (win_i || win_d) begin
          s1 = (c + 1) % 32;
          sr = (c + 2 + LAT) % 32;
          e_ctl[s1][win_i ? 5 : 4] = 1'b1;
          e_ctl[s1][1] = 1'b1;
          e_addr[s1] = win_i ? i_addr : d_addr;
          e_we[s1]   = win_d && d_we;
          e_wd[s1]   = d_wdata;
          for (int k = 1; k <= 2 + LAT; k++) e_ctl[(c + k) % 32][0] = 1'b1;
          e_ctl[sr][win_i ? 3 : 2] = 1'b1;
          if (win_i) begin
            e_rd[sr] = shadow[i_addr[7:0]];
          end else if (!d_we) begin
            e_rd[sr] = shadow[d_addr[7:0]];
            e_ld[sr] = 1'b1;
          end else begin
            shadow[d_addr[7:0]] = d_wdata;
          end
          next_arb = c + 2 + LAT;
        end
      end
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_store();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
